// File: rtl/ifu_pc_fetch.sv
// PC owner and instruction fetch unit: requests the word at pc, captures the
// response, offers it to decode, and advances pc on each commit.
module ifu_pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h80000000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      next_pc,
    input  logic             pc_update,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [31:0]      imem_req_addr,
    input  logic             imem_rsp_valid,
    input  logic [31:0]      imem_rsp_data,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [31:0]      inst,
    output logic [31:0]      pc,
    output logic             fetch_fault,
    output logic [CNT_W-1:0] commit_cnt,
    output logic [2:0]       state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; valid, once raised, holds with stable payload until then.
    typedef enum logic [2:0] {
        S_REQ   = 3'd0,
        S_WAIT  = 3'd1,
        S_HOLD  = 3'd2,
        S_EXEC  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [31:0]       r_pc;
    logic [31:0]       r_inst;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_fault;
    logic              w_commit;
    logic              w_misaligned;

    assign w_misaligned = |next_pc[1:0];

    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        case (r_state)
            S_REQ:   if (imem_req_ready) w_state_nxt = S_WAIT;
            S_WAIT:  if (imem_rsp_valid) w_state_nxt = S_HOLD;
            S_HOLD: begin
                if (inst_ready) begin
                    if (pc_update) w_commit = 1'b1;
                    else           w_state_nxt = S_EXEC;
                end
            end
            S_EXEC:  if (pc_update) w_commit = 1'b1;
            S_FAULT: w_state_nxt = S_FAULT;
            default: w_state_nxt = S_FAULT;
        endcase
        if (w_commit) w_state_nxt = w_misaligned ? S_FAULT : S_REQ;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_REQ;
            r_pc    <= RESET_PC;
            r_inst  <= 32'h0;
            r_cnt   <= '0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_WAIT && imem_rsp_valid) r_inst <= imem_rsp_data;
            if (w_commit) begin
                r_pc  <= next_pc;
                r_cnt <= r_cnt + CNT_W'(1);
                if (w_misaligned) r_fault <= 1'b1;
            end
        end
    end

    // The reset state is S_REQ, so the request is masked while rst is held.
    assign imem_req_valid = (r_state == S_REQ) && !rst;
    assign imem_req_addr  = r_pc;
    assign inst_valid     = (r_state == S_HOLD);
    assign inst           = r_inst;
    assign pc             = r_pc;
    assign fetch_fault    = r_fault;
    assign commit_cnt     = r_cnt;
    assign state_dbg      = r_state;

endmodule

// File: tb/tb_ifu_pc_fetch.sv
// Directed bench for ifu_pc_fetch: a vector table walked cycle by cycle, then
// hand-written reset sequences.
module tb_ifu_pc_fetch;

    localparam logic [31:0] RST_PC = 32'h80000000;
    localparam logic [2:0] ST_REQ = 3'd0, ST_WAIT = 3'd1, ST_HOLD = 3'd2,
                           ST_EXEC = 3'd3, ST_FAULT = 3'd4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] next_pc;
    logic        pc_update;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fetch_fault;
    logic [31:0] commit_cnt;
    logic [2:0]  state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    ifu_pc_fetch #(.RESET_PC(RST_PC), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .next_pc(next_pc), .pc_update(pc_update),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .inst(inst), .pc(pc),
        .fetch_fault(fetch_fault), .commit_cnt(commit_cnt), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rdy;
        logic        rsp_v;
        logic [31:0] rsp_d;
        logic        i_rdy;
        logic        pu;
        logic [31:0] npc;
        logic [2:0]  e_state;
        logic        e_req_v;
        logic [31:0] e_pc;
        logic        e_inst_v;
        logic [31:0] e_inst;
        logic        e_fault;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vq[$];

    task automatic add(input string nm, input logic rdy, input logic rv,
                       input logic [31:0] rd, input logic ir, input logic pu,
                       input logic [31:0] np, input logic [2:0] es, input logic erv,
                       input logic [31:0] epc, input logic eiv, input logic [31:0] ei,
                       input logic ef, input logic [31:0] ec);
        vec_t v;
        v.name = nm; v.rdy = rdy; v.rsp_v = rv; v.rsp_d = rd; v.i_rdy = ir;
        v.pu = pu; v.npc = np; v.e_state = es; v.e_req_v = erv; v.e_pc = epc;
        v.e_inst_v = eiv; v.e_inst = ei; v.e_fault = ef; v.e_cnt = ec;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rdy, input logic rv, input logic [31:0] rd,
                         input logic ir, input logic pu, input logic [31:0] np);
        imem_req_ready = rdy; imem_rsp_valid = rv; imem_rsp_data = rd;
        inst_ready = ir; pc_update = pu; next_pc = np;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

        //   name          rdy rv  rsp_data      ir pu next_pc       state     rqv pc            iv inst          flt cnt
        add("accept",      1, 0, 32'h0,        0, 0, 32'h0,        ST_WAIT,  0, RST_PC,       0, 32'h0,        0, 0);
        add("rsp0",        0, 1, 32'h00000013, 0, 0, 32'h0,        ST_HOLD,  0, RST_PC,       1, 32'h00000013, 0, 0);
        add("hold_spur",   0, 1, 32'hDEADBEEF, 0, 0, 32'h0,        ST_HOLD,  0, RST_PC,       1, 32'h00000013, 0, 0);
        add("hold_bp2",    0, 0, 32'h0,        0, 0, 32'h0,        ST_HOLD,  0, RST_PC,       1, 32'h00000013, 0, 0);
        add("hold_bp3",    0, 0, 32'h0,        0, 0, 32'h0,        ST_HOLD,  0, RST_PC,       1, 32'h00000013, 0, 0);
        add("hold_bp4",    0, 0, 32'h0,        0, 0, 32'h0,        ST_HOLD,  0, RST_PC,       1, 32'h00000013, 0, 0);
        add("to_exec",     0, 0, 32'h0,        1, 0, 32'h0,        ST_EXEC,  0, RST_PC,       0, 32'h00000013, 0, 0);
        add("exec_wait",   0, 0, 32'h0,        0, 0, 32'h0,        ST_EXEC,  0, RST_PC,       0, 32'h00000013, 0, 0);
        add("commit1",     0, 0, 32'h0,        0, 1, 32'h80000004, ST_REQ,   1, 32'h80000004, 0, 32'h00000013, 0, 1);
        add("req_bp1",     0, 0, 32'h0,        0, 0, 32'h0,        ST_REQ,   1, 32'h80000004, 0, 32'h00000013, 0, 1);
        add("req_bp2",     0, 0, 32'h0,        0, 0, 32'h0,        ST_REQ,   1, 32'h80000004, 0, 32'h00000013, 0, 1);
        add("req_bp3",     0, 0, 32'h0,        0, 0, 32'h0,        ST_REQ,   1, 32'h80000004, 0, 32'h00000013, 0, 1);
        add("req_bp4",     0, 0, 32'h0,        0, 0, 32'h0,        ST_REQ,   1, 32'h80000004, 0, 32'h00000013, 0, 1);
        add("req_bp5",     0, 1, 32'h11111111, 0, 1, 32'h12345678, ST_REQ,   1, 32'h80000004, 0, 32'h00000013, 0, 1);
        add("accept2",     1, 0, 32'h0,        0, 1, 32'h12345678, ST_WAIT,  0, 32'h80000004, 0, 32'h00000013, 0, 1);
        add("wait_spur",   0, 0, 32'h0,        1, 1, 32'h11111110, ST_WAIT,  0, 32'h80000004, 0, 32'h00000013, 0, 1);
        add("rsp1",        0, 1, 32'h00100093, 0, 0, 32'h0,        ST_HOLD,  0, 32'h80000004, 1, 32'h00100093, 0, 1);
        add("same_cyc1",   0, 0, 32'h0,        1, 1, 32'h80000008, ST_REQ,   1, 32'h80000008, 0, 32'h00100093, 0, 2);
        add("accept3",     1, 0, 32'h0,        0, 0, 32'h0,        ST_WAIT,  0, 32'h80000008, 0, 32'h00100093, 0, 2);
        add("rsp2",        0, 1, 32'h00200113, 0, 0, 32'h0,        ST_HOLD,  0, 32'h80000008, 1, 32'h00200113, 0, 2);
        add("same_cyc2",   0, 0, 32'h0,        1, 1, 32'h80000100, ST_REQ,   1, 32'h80000100, 0, 32'h00200113, 0, 3);
        add("accept4",     1, 0, 32'h0,        0, 0, 32'h0,        ST_WAIT,  0, 32'h80000100, 0, 32'h00200113, 0, 3);
        add("rsp3",        0, 1, 32'h00300193, 0, 0, 32'h0,        ST_HOLD,  0, 32'h80000100, 1, 32'h00300193, 0, 3);
        add("to_exec2",    0, 0, 32'h0,        1, 0, 32'h0,        ST_EXEC,  0, 32'h80000100, 0, 32'h00300193, 0, 3);
        add("misalign",    0, 0, 32'h0,        0, 1, 32'h80000102, ST_FAULT, 0, 32'h80000102, 0, 32'h00300193, 1, 4);
        add("fault_stay1", 1, 1, 32'hCAFEF00D, 1, 1, 32'h80000200, ST_FAULT, 0, 32'h80000102, 0, 32'h00300193, 1, 4);
        add("fault_stay2", 1, 0, 32'h0,        1, 1, 32'h80000300, ST_FAULT, 0, 32'h80000102, 0, 32'h00300193, 1, 4);

        // Reset values while rst is held.
        step();
        step();
        chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
        chk("rst_inst_valid", 32'(inst_valid), 32'h0);
        chk("rst_pc", pc, RST_PC);
        chk("rst_inst", inst, 32'h0);
        chk("rst_cnt", commit_cnt, 32'h0);
        chk("rst_fault", 32'(fetch_fault), 32'h0);
        chk("rst_state", 32'(state_dbg), 32'(ST_REQ));

        rst = 1'b0;
        #1;
        chk("rel_req_valid", 32'(imem_req_valid), 32'h1);
        chk("rel_req_addr", imem_req_addr, RST_PC);

        foreach (vq[i]) begin
            drive(vq[i].rdy, vq[i].rsp_v, vq[i].rsp_d, vq[i].i_rdy, vq[i].pu, vq[i].npc);
            step();
            chk({vq[i].name, ".state"}, 32'(state_dbg), 32'(vq[i].e_state));
            chk({vq[i].name, ".req_valid"}, 32'(imem_req_valid), 32'(vq[i].e_req_v));
            chk({vq[i].name, ".req_addr"}, imem_req_addr, vq[i].e_pc);
            chk({vq[i].name, ".pc"}, pc, vq[i].e_pc);
            chk({vq[i].name, ".inst_valid"}, 32'(inst_valid), 32'(vq[i].e_inst_v));
            chk({vq[i].name, ".inst"}, inst, vq[i].e_inst);
            chk({vq[i].name, ".fault"}, 32'(fetch_fault), 32'(vq[i].e_fault));
            chk({vq[i].name, ".cnt"}, commit_cnt, vq[i].e_cnt);
        end

        // Reset out of S_FAULT clears the sticky fault.
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        #1;
        chk("frst_fault", 32'(fetch_fault), 32'h0);
        chk("frst_pc", pc, RST_PC);
        chk("frst_cnt", commit_cnt, 32'h0);
        chk("frst_state", 32'(state_dbg), 32'(ST_REQ));
        step();
        rst = 1'b0;

        // Fetch, commit, then reset asynchronously in the middle of S_WAIT.
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step();
        chk("seq_wait", 32'(state_dbg), 32'(ST_WAIT));
        drive(1'b0, 1'b1, 32'hAAAA5555, 1'b0, 1'b0, 32'h0);
        step();
        chk("seq_inst", inst, 32'hAAAA5555);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h80000010);
        step();
        chk("seq_addr", imem_req_addr, 32'h80000010);
        chk("seq_cnt", commit_cnt, 32'h1);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step();
        chk("seq_wait2", 32'(state_dbg), 32'(ST_WAIT));
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_req_valid", 32'(imem_req_valid), 32'h0);
        chk("mid_rst_inst_valid", 32'(inst_valid), 32'h0);
        chk("mid_rst_pc", pc, RST_PC);
        chk("mid_rst_inst", inst, 32'h0);
        chk("mid_rst_cnt", commit_cnt, 32'h0);
        step();
        rst = 1'b0;
        #1;
        chk("refetch_valid", 32'(imem_req_valid), 32'h1);
        chk("refetch_addr", imem_req_addr, RST_PC);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step();
        chk("refetch_wait", 32'(state_dbg), 32'(ST_WAIT));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
